// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/WB/flow encodings, ID/EX payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decode_stage_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASSB  = 4'd10;
    localparam logic [3:0] ALU_ADD_PC = 4'd11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] FLOW_NONE   = 2'b00;
    localparam logic [1:0] FLOW_BRANCH = 2'b01;
    localparam logic [1:0] FLOW_JAL    = 2'b10;
    localparam logic [1:0] FLOW_JALR   = 2'b11;

    // ID/EX pipeline payload; an all-zero value is a bubble.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic [1:0]  flow;
    } idex_t;

    // funct3 to ALU op; alt is instruction bit 30 where it selects SUB/SRA.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Register file: 2 async read ports with write-then-read bypass, 1 sync write port; x0 reads 0.
// Latency: reads combinational, writes land on the rising clk edge.
// Backpressure: none; writes are always accepted.
module decode_stage_regfile #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);
    logic [31:0] r_regs [NUM_REGS];
    logic        w_wr_en;

    assign w_wr_en = i_we && (i_waddr != 5'd0);

    // Write port; reset clears every register, x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read ports: x0 is zero, a same-cycle write to the read index is forwarded.
    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        o_rdata2 = r_regs[i_raddr2];
        if (w_wr_en && i_waddr == i_raddr1) o_rdata1 = i_wdata;
        if (w_wr_en && i_waddr == i_raddr2) o_rdata2 = i_wdata;
        if (i_raddr1 == 5'd0) o_rdata1 = '0;
        if (i_raddr2 == 5'd0) o_rdata2 = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode: immediates, control, register read, load-use detect, ID/EX register.
// Latency: 1 cycle from instruction to ID/EX outputs; o_stall is combinational.
// Backpressure: load-use raises o_stall and inserts a bubble; flush overrides stall.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] pc,
    input  logic [31:0] pc4,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        o_stall,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [2:0]  o_funct3,
    output logic [3:0]  o_alu_op,
    output logic        o_alu_src,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_reg_write,
    output logic [1:0]  o_wb_sel,
    output logic [1:0]  o_flow
);
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1_f, w_rs2_f, w_rd_f;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_valid, w_use_rs1, w_use_rs2, w_stall;
    logic [4:0]  w_rs1_idx, w_rs2_idx;
    logic [31:0] w_rs1_data, w_rs2_data;
    idex_t       w_dec, w_next, r_idex;

    assign w_opcode = instruction[6:0];
    assign w_funct3 = instruction[14:12];
    assign w_rd_f   = instruction[11:7];
    assign w_rs1_f  = instruction[19:15];
    assign w_rs2_f  = instruction[24:20];

    assign w_imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign w_imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign w_imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
    assign w_imm_u = {instruction[31:12], 12'd0};
    assign w_imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};

    // Operand usage drives both the register read index and hazard detection; lui reads x0.
    assign w_valid   = w_opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    assign w_use_rs1 = w_opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    assign w_use_rs2 = w_opcode inside {OP_R, OP_STORE, OP_BRANCH};
    assign w_rs1_idx = w_use_rs1 ? w_rs1_f : 5'd0;
    assign w_rs2_idx = w_use_rs2 ? w_rs2_f : 5'd0;

    assign w_stall = !flush && ex_mem_read && (ex_rd != 5'd0) &&
                     ((w_use_rs1 && w_rs1_f == ex_rd) || (w_use_rs2 && w_rs2_f == ex_rd));
    assign o_stall = w_stall;

    decode_stage_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (w_rs1_idx),
        .i_raddr2 (w_rs2_idx),
        .o_rdata1 (w_rs1_data),
        .o_rdata2 (w_rs2_data),
        .i_we     (wb_we),
        .i_waddr  (wb_rd),
        .i_wdata  (wb_data)
    );

    // Per-opcode control and immediate selection; unknown opcodes keep all-zero control.
    always_comb begin
        w_dec = '0;
        case (w_opcode)
            OP_R: begin
                w_dec.alu_op = alu_decode(w_funct3, instruction[30]);
                w_dec.reg_write = 1'b1;
                w_dec.funct3 = w_funct3;
            end
            OP_I: begin
                w_dec.alu_op = alu_decode(w_funct3, (w_funct3 == 3'b101) && instruction[30]);
                w_dec.alu_src = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.imm = w_imm_i;
                w_dec.funct3 = w_funct3;
            end
            OP_LOAD: begin
                w_dec.alu_src = 1'b1;
                w_dec.mem_read = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.wb_sel = WB_MEM;
                w_dec.imm = w_imm_i;
                w_dec.funct3 = w_funct3;
            end
            OP_STORE: begin
                w_dec.alu_src = 1'b1;
                w_dec.mem_write = 1'b1;
                w_dec.imm = w_imm_s;
                w_dec.funct3 = w_funct3;
            end
            OP_BRANCH: begin
                w_dec.alu_op = ALU_SUB;
                w_dec.flow = FLOW_BRANCH;
                w_dec.imm = w_imm_b;
                w_dec.funct3 = w_funct3;
            end
            OP_JAL: begin
                w_dec.alu_op = ALU_ADD_PC;
                w_dec.alu_src = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.wb_sel = WB_PC4;
                w_dec.flow = FLOW_JAL;
                w_dec.imm = w_imm_j;
            end
            OP_JALR: begin
                w_dec.alu_src = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.wb_sel = WB_PC4;
                w_dec.flow = FLOW_JALR;
                w_dec.imm = w_imm_i;
                w_dec.funct3 = w_funct3;
            end
            OP_LUI: begin
                w_dec.alu_op = ALU_PASSB;
                w_dec.alu_src = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.imm = w_imm_u;
            end
            OP_AUIPC: begin
                w_dec.alu_op = ALU_ADD_PC;
                w_dec.alu_src = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.imm = w_imm_u;
            end
            default: w_dec = '0;
        endcase
    end

    // Attach operand indices, register data and pc to the decoded control.
    always_comb begin
        w_next = w_dec;
        w_next.pc = pc;
        w_next.pc4 = pc4;
        w_next.rs1 = w_rs1_idx;
        w_next.rs2 = w_rs2_idx;
        w_next.rs1_data = w_rs1_data;
        w_next.rs2_data = w_rs2_data;
        w_next.rd = w_dec.reg_write ? w_rd_f : 5'd0;
    end

    // ID/EX register: bubble on reset, flush, stall or a non-instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idex <= '0;
        end else if (flush || w_stall || !w_valid) begin
            r_idex <= '0;
        end else begin
            r_idex <= w_next;
        end
    end

    assign o_pc        = r_idex.pc;
    assign o_pc4       = r_idex.pc4;
    assign o_rs1_data  = r_idex.rs1_data;
    assign o_rs2_data  = r_idex.rs2_data;
    assign o_imm       = r_idex.imm;
    assign o_rs1       = r_idex.rs1;
    assign o_rs2       = r_idex.rs2;
    assign o_rd        = r_idex.rd;
    assign o_funct3    = r_idex.funct3;
    assign o_alu_op    = r_idex.alu_op;
    assign o_alu_src   = r_idex.alu_src;
    assign o_mem_read  = r_idex.mem_read;
    assign o_mem_write = r_idex.mem_write;
    assign o_reg_write = r_idex.reg_write;
    assign o_wb_sel    = r_idex.wb_sel;
    assign o_flow      = r_idex.flow;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed literal cases plus random stream vs. model.
// Latency: model expects ID/EX one edge after inputs, o_stall same cycle.
// Backpressure: stall/flush modelled as bubbles in the expected ID/EX value.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction, pc, pc4;
    logic        flush, ex_mem_read, wb_we;
    logic [4:0]  ex_rd, wb_rd;
    logic [31:0] wb_data;
    logic        o_stall, o_alu_src, o_mem_read, o_mem_write, o_reg_write;
    logic [31:0] o_pc, o_pc4, o_rs1_data, o_rs2_data, o_imm;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [2:0]  o_funct3;
    logic [3:0]  o_alu_op;
    logic [1:0]  o_wb_sel, o_flow;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [32];
    idex_t       exp_idex;

    decode_stage dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .pc4(pc4),
        .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .o_stall(o_stall), .o_pc(o_pc), .o_pc4(o_pc4),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_funct3(o_funct3),
        .o_alu_op(o_alu_op), .o_alu_src(o_alu_src), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_reg_write(o_reg_write),
        .o_wb_sel(o_wb_sel), .o_flow(o_flow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Register read as seen by decode: x0 is zero, a same-cycle writeback wins.
    function automatic logic [31:0] rd_reg(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (wb_we && wb_rd == idx) return wb_data;
        return mregs[idx];
    endfunction

    function automatic logic uses1(input logic [31:0] ins);
        return ins[6:0] inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    endfunction

    function automatic logic uses2(input logic [31:0] ins);
        return ins[6:0] inside {OP_R, OP_STORE, OP_BRANCH};
    endfunction

    function automatic logic model_stall();
        if (flush || !ex_mem_read || ex_rd == 0) return 1'b0;
        return (uses1(instruction) && instruction[19:15] == ex_rd) ||
               (uses2(instruction) && instruction[24:20] == ex_rd);
    endfunction

    // Immediates built arithmetically from their scattered bit fields.
    function automatic logic [31:0] imm_of(input logic [31:0] ins, input byte fmt);
        logic [31:0] v;
        logic [31:0] s;
        s = ins[31] ? 32'hFFFFFFFF : 32'd0;
        case (fmt)
            "I": v = (s << 12) + 32'(ins[31:20]);
            "S": v = (s << 12) + 32'(ins[31:25]) * 32 + 32'(ins[11:7]);
            "B": v = (s << 12) + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
            "U": v = ins & 32'hFFFFF000;
            "J": v = (s << 20) + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [3:0] tbl [8];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (f3 == 3'd0 && alt) return ALU_SUB;
        if (f3 == 3'd5 && alt) return ALU_SRA;
        return tbl[f3];
    endfunction

    // Expected ID/EX contents for the current inputs, from the ISA rules.
    function automatic idex_t model_idex();
        idex_t e;
        byte   fmt;
        logic  wr;
        logic [6:0] op;
        e = '0;
        op = instruction[6:0];
        fmt = "R";
        wr = 1'b1;
        if (flush || model_stall()) return e;
        case (op)
            OP_R:      e.alu_op = alu_of(instruction[14:12], instruction[30]);
            OP_I:    begin fmt = "I"; e.alu_op = alu_of(instruction[14:12], instruction[14:12] == 5 && instruction[30]); end
            OP_LOAD: begin fmt = "I"; e.mem_read = 1; e.wb_sel = WB_MEM; end
            OP_STORE:begin fmt = "S"; e.mem_write = 1; wr = 0; end
            OP_BRANCH:begin fmt = "B"; e.alu_op = ALU_SUB; e.flow = FLOW_BRANCH; wr = 0; end
            OP_JAL:  begin fmt = "J"; e.alu_op = ALU_ADD_PC; e.wb_sel = WB_PC4; e.flow = FLOW_JAL; end
            OP_JALR: begin fmt = "I"; e.wb_sel = WB_PC4; e.flow = FLOW_JALR; end
            OP_LUI:  begin fmt = "U"; e.alu_op = ALU_PASSB; end
            OP_AUIPC:begin fmt = "U"; e.alu_op = ALU_ADD_PC; end
            default: return e;
        endcase
        e.imm = imm_of(instruction, fmt);
        e.alu_src = (fmt != "R" && fmt != "B");
        e.reg_write = wr;
        e.rd = wr ? instruction[11:7] : 5'd0;
        if (!(op inside {OP_JAL, OP_LUI, OP_AUIPC})) e.funct3 = instruction[14:12];
        e.rs1 = uses1(instruction) ? instruction[19:15] : 5'd0;
        e.rs2 = uses2(instruction) ? instruction[24:20] : 5'd0;
        e.rs1_data = rd_reg(e.rs1);
        e.rs2_data = rd_reg(e.rs2);
        e.pc = pc;
        e.pc4 = pc4;
        return e;
    endfunction

    // Model state update on each edge: capture ID/EX, then apply writeback.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_idex = '0;
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else begin
            exp_idex = model_idex();
            if (wb_we && wb_rd != 0) mregs[wb_rd] = wb_data;
        end
    end

    // Compare process: every falling edge, full ID/EX bundle and the stall output.
    initial begin
        idex_t act;
        @(posedge clk);
        forever begin
            @(negedge clk);
            act = '{o_pc, o_pc4, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd,
                    o_funct3, o_alu_op, o_alu_src, o_mem_read, o_mem_write,
                    o_reg_write, o_wb_sel, o_flow};
            checks++;
            if (act !== exp_idex) begin
                errors++;
                $display("FAIL idex @%0t: got %h expected %h", $time, act, exp_idex);
            end
            checks++;
            if (o_stall !== model_stall()) begin
                errors++;
                $display("FAIL stall @%0t: got %b expected %b", $time, o_stall, model_stall());
            end
        end
    end

    initial begin
        logic [6:0] ops [11];
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
                OP_LUI, OP_AUIPC, 7'h7F, 7'h00};
        rst = 1; instruction = 0; pc = 0; pc4 = 0; flush = 0;
        ex_mem_read = 0; ex_rd = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        cyc();
        chk("reset_pc", o_pc, 32'd0);
        chk("reset_ctl", {21'd0, o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_alu_op, o_rd}, 32'd0);
        rst = 0;

        // addi x1,x0,5
        instruction = 32'h00500093; pc = 32'h100; pc4 = 32'h104;
        cyc();
        chk("addi_imm", o_imm, 32'd5);
        chk("addi_ctl", {24'd0, o_rd, o_alu_src, o_reg_write, 1'b0}, {24'd0, 5'd1, 1'b1, 1'b1, 1'b0});
        chk("addi_aluop", {28'd0, o_alu_op}, {28'd0, ALU_ADD});
        chk("addi_pc", o_pc, 32'h100);

        // add x3,x2,x1 behind a load writing x2
        instruction = 32'h001101B3; ex_mem_read = 1; ex_rd = 2;
        #1 chk("loaduse_stall", {31'd0, o_stall}, 32'd1);
        cyc();
        chk("loaduse_bubble", {o_pc[15:0], 4'd0, o_alu_op, o_rd, o_reg_write, o_alu_src, o_mem_read}, 32'd0);
        ex_mem_read = 0;
        #1 chk("loaduse_clear", {31'd0, o_stall}, 32'd0);
        cyc();
        chk("add_rd_rs", {17'd0, o_rd, o_rs1, o_rs2}, {17'd0, 5'd3, 5'd2, 5'd1});

        // add x6,x5,x0 with x5 written in the same cycle
        instruction = 32'h00028333; wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        cyc();
        chk("bypass_rs1", o_rs1_data, 32'hDEADBEEF);
        instruction = 32'h00000333; wb_rd = 0; wb_data = 32'h12345678;
        cyc();
        chk("x0_write_ignored", o_rs1_data, 32'd0);
        instruction = 32'h00028333; wb_we = 0;
        cyc();
        chk("x5_stored", o_rs1_data, 32'hDEADBEEF);

        // beq x0,x0,-8
        instruction = 32'hFE000CE3; pc = 32'h200; pc4 = 32'h204;
        cyc();
        chk("beq_imm", o_imm, 32'hFFFFFFF8);
        chk("beq_ctl", {23'd0, o_flow, o_reg_write, o_rd}, {23'd0, 2'b01, 1'b0, 5'd0});

        // flush overrides a load-use hazard
        instruction = 32'h001101B3; ex_mem_read = 1; ex_rd = 1; flush = 1;
        #1 chk("flush_stall", {31'd0, o_stall}, 32'd0);
        cyc();
        chk("flush_bubble", {o_pc[23:0], o_rd, o_reg_write, o_flow}, 32'd0);
        flush = 0; ex_mem_read = 0;

        for (int n = 0; n < 2000; n++) begin
            instruction = $urandom;
            instruction[6:0] = ops[$urandom_range(0, 10)];
            instruction[11:7] = 5'($urandom_range(0, 7));
            instruction[19:15] = 5'($urandom_range(0, 7));
            instruction[24:20] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) instruction = 32'd0;
            pc = $urandom & 32'hFFFFFFFC; pc4 = pc + 4;
            flush = ($urandom_range(0, 7) == 0);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_rd = 5'($urandom_range(0, 7));
            wb_we = $urandom_range(0, 1) == 1;
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            cyc();
        end

        // write x1, then reset mid-cycle and read x1 back
        flush = 0; ex_mem_read = 0;
        instruction = 32'h000081B3; wb_we = 1; wb_rd = 1; wb_data = 32'h55;
        cyc();
        chk("x1_written", o_rs1_data, 32'h55);
        wb_we = 0;
        #2 rst = 1;
        #1 chk("async_rst_ctl", {21'd0, o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_alu_op, o_rd}, 32'd0);
        chk("async_rst_pc", o_pc, 32'd0);
        cyc();
        rst = 0;
        cyc();
        chk("x1_after_rst", o_rs1_data, 32'd0);
        chk("rd_after_rst", {27'd0, o_rd}, 32'd3);
        cyc();
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
